pipelined_adder: RTL

//  Parametrised, pipelined WIDTH-bit adder with carry-in. Successor to the 1-bit adder cells.

---
 rtl/pipelined_adder_pkg.sv | 12 +
 rtl/adder_stage.sv | 65 ++++++
 rtl/pipelined_adder.sv | 76 +++++++
 3 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and configuration legality.
package pipelined_adder_pkg;

    function automatic int chunk_width(input int width, input int stages);
        return (stages >= 1) ? width / stages : width;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (width % stages == 0);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One pipeline stage: adds chunk IDX with the incoming carry and registers the partially
// built sum together with the operands still needed by later stages.
module adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int CW    = 4,
    parameter int WIDTH = 16,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] s_in,
    input  logic             carry_in,
    output logic             valid,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic             carry,
    output logic             ovf
);
    localparam int LO   = IDX * CW;
    localparam bit LAST = (LO + CW == WIDTH);

    logic [CW:0]      chunk_sum;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] chunk_ext;
    logic [WIDTH-1:0] s_next;
    logic             msb_cin;
    logic             ovf_next;

    always_comb begin
        chunk_sum = {1'b0, x_in[LO +: CW]} + {1'b0, y_in[LO +: CW]} + {{CW{1'b0}}, carry_in};
        mask = '0;
        mask[LO +: CW] = '1;
        chunk_ext = '0;
        chunk_ext[LO +: CW] = chunk_sum[CW-1:0];
        s_next = (s_in & ~mask) | chunk_ext;
        // carry into the MSB recovered from the MSB sum bit; only meaningful in the top chunk
        msb_cin = x_in[WIDTH-1] ^ y_in[WIDTH-1] ^ chunk_sum[CW-1];
        ovf_next = LAST ? (msb_cin ^ chunk_sum[CW]) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            x     <= '0;
            y     <= '0;
            s     <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (en) begin
            valid <= valid_in;
            x     <= x_in;
            y     <= y_in;
            s     <= s_next;
            carry <= chunk_sum[CW];
            ovf   <= ovf_next;
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder with carry-in: one CW-bit chunk per stage, carry rippled through
// registers, valid/ready on both sides with combinational ready propagation.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES must be >= 1");
    end

    // index 0 is the input side, index k+1 is the register set of stage k
    logic [STAGES:0]  v;
    logic [STAGES:0]  c_p;
    logic [WIDTH-1:0] x_p [STAGES+1];
    logic [WIDTH-1:0] y_p [STAGES+1];
    logic [WIDTH-1:0] s_p [STAGES+1];
    logic             ovf_p [STAGES];
    logic             en [STAGES+1];

    assign v[0]        = in_valid;
    assign c_p[0]      = cin;
    assign x_p[0]      = x;
    assign y_p[0]      = y;
    assign s_p[0]      = '0;
    assign en[STAGES]  = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .CW    (CW),
            .WIDTH (WIDTH),
            .IDX   (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en[k]),
            .valid_in (v[k]),
            .x_in     (x_p[k]),
            .y_in     (y_p[k]),
            .s_in     (s_p[k]),
            .carry_in (c_p[k]),
            .valid    (v[k+1]),
            .x        (x_p[k+1]),
            .y        (y_p[k+1]),
            .s        (s_p[k+1]),
            .carry    (c_p[k+1]),
            .ovf      (ovf_p[k])
        );

        // a bubble can always be overwritten, so stalls only back up through valid stages
        assign en[k] = !v[k+1] || en[k+1];
    end

    assign in_ready  = en[0];
    assign out_valid = v[STAGES];
    assign s         = s_p[STAGES];
    assign cout      = c_p[STAGES];
    assign ovf       = ovf_p[STAGES-1];

endmodule
